// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake plus ALU drive bundle for alu_issue_ctrl.
// Latency: none (wires only).
// Backpressure: req_ready/rsp_ready carry flow control in each direction.
interface alu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_funct;
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic [31:0] alu_dataA;
    logic [31:0] alu_dataB;
    logic [5:0]  alu_signal;
    logic        alu_reset;
    logic [31:0] alu_out;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_is_div;
    logic        rsp_err;

    // Controller side: consumes requests and ALU output, drives everything else.
    modport slave (
        input  req_valid, req_funct, req_a, req_b, rsp_ready, alu_out,
        output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_is_div, rsp_err,
        output alu_dataA, alu_dataB, alu_signal, alu_reset
    );

    // Environment side: issues requests, models the ALU, accepts responses.
    modport master (
        output req_valid, req_funct, req_a, req_b, rsp_ready, alu_out,
        input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_is_div, rsp_err,
        input  alu_dataA, alu_dataB, alu_signal, alu_reset
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Sequences one ALU command at a time (single-cycle ops and the DIVU reset/run/MFHI/MFLO flow).
// Latency: OP_WAIT for single ops, 1 for illegal funct, 1+DIV_WAIT+2*OP_WAIT for DIVU.
// Backpressure: one command in flight; req_ready low until the response handshakes.
module alu_issue_ctrl #(
    parameter int unsigned OP_WAIT  = 1,
    parameter int unsigned DIV_WAIT = 35
) (
    input  logic             clk,
    input  logic             reset,
    alu_issue_ctrl_if.slave  bus
);
    localparam logic [5:0] F_AND  = 6'd36;
    localparam logic [5:0] F_OR   = 6'd37;
    localparam logic [5:0] F_ADD  = 6'd32;
    localparam logic [5:0] F_SUB  = 6'd34;
    localparam logic [5:0] F_SLT  = 6'd42;
    localparam logic [5:0] F_SRL  = 6'd2;
    localparam logic [5:0] F_MFHI = 6'd16;
    localparam logic [5:0] F_MFLO = 6'd18;
    localparam logic [5:0] F_DIVU = 6'd27;

    localparam logic [7:0] OP_M1  = 8'(OP_WAIT - 1);
    localparam logic [7:0] DIV_M1 = 8'(DIV_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_DRST, S_DRUN, S_MFHI, S_MFLO, S_RESP
    } state_t;

    state_t      r_state, w_state;
    logic [7:0]  r_cnt, w_cnt;
    logic        r_req_ready, w_req_ready;
    logic        r_rsp_valid, w_rsp_valid;
    logic [31:0] r_rsp_lo, w_rsp_lo;
    logic [31:0] r_rsp_hi, w_rsp_hi;
    logic        r_rsp_is_div, w_rsp_is_div;
    logic        r_rsp_err, w_rsp_err;
    logic [31:0] r_alu_a, w_alu_a;
    logic [31:0] r_alu_b, w_alu_b;
    logic [5:0]  r_alu_signal, w_alu_signal;
    logic        r_alu_reset, w_alu_reset;
    logic        w_last;
    logic        w_single;

    assign w_last = (r_cnt == 8'd0);

    // Funct codes that complete in one ALU pass (MFHI/MFLO read whatever the ALU holds).
    always_comb begin
        w_single = 1'b0;
        case (bus.req_funct)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_MFHI, F_MFLO: w_single = 1'b1;
            default:                                                 w_single = 1'b0;
        endcase
    end

    // Next state and next value of every registered output.
    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_rsp_lo     = r_rsp_lo;
        w_rsp_hi     = r_rsp_hi;
        w_rsp_is_div = r_rsp_is_div;
        w_rsp_err    = r_rsp_err;
        w_alu_a      = r_alu_a;
        w_alu_b      = r_alu_b;
        w_alu_signal = r_alu_signal;
        w_alu_reset  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid && r_req_ready) begin
                    w_rsp_lo     = '0;
                    w_rsp_hi     = '0;
                    w_rsp_is_div = 1'b0;
                    w_rsp_err    = 1'b0;
                    if (w_single) begin
                        w_state      = S_EXEC;
                        w_cnt        = OP_M1;
                        w_alu_a      = bus.req_a;
                        w_alu_b      = bus.req_b;
                        w_alu_signal = bus.req_funct;
                    end else if (bus.req_funct == F_DIVU) begin
                        w_state      = S_DRST;
                        w_alu_a      = bus.req_a;
                        w_alu_b      = bus.req_b;
                        w_alu_signal = F_DIVU;
                        w_alu_reset  = 1'b1;
                    end else begin
                        // Illegal funct spends one idle EXEC cycle so the response
                        // arrives one cycle after accept; the ALU is never driven.
                        w_state   = S_EXEC;
                        w_cnt     = 8'd0;
                        w_rsp_err = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (w_last) begin
                    w_rsp_lo     = r_rsp_err ? 32'd0 : bus.alu_out;
                    w_rsp_hi     = '0;
                    w_state      = S_RESP;
                    w_alu_a      = '0;
                    w_alu_b      = '0;
                    w_alu_signal = F_AND;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            S_DRST: begin
                w_state = S_DRUN;
                w_cnt   = DIV_M1;
            end
            S_DRUN: begin
                if (w_last) begin
                    w_state      = S_MFHI;
                    w_alu_signal = F_MFHI;
                    w_cnt        = OP_M1;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            S_MFHI: begin
                if (w_last) begin
                    w_rsp_hi     = bus.alu_out;
                    w_state      = S_MFLO;
                    w_alu_signal = F_MFLO;
                    w_cnt        = OP_M1;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            S_MFLO: begin
                if (w_last) begin
                    w_rsp_lo     = bus.alu_out;
                    w_rsp_is_div = 1'b1;
                    w_state      = S_RESP;
                    w_alu_a      = '0;
                    w_alu_b      = '0;
                    w_alu_signal = F_AND;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
        w_req_ready = (w_state == S_IDLE);
        w_rsp_valid = (w_state == S_RESP);
    end

    // State and output registers; synchronous reset holds the ALU in reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_req_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_lo     <= '0;
            r_rsp_hi     <= '0;
            r_rsp_is_div <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_signal <= F_AND;
            r_alu_reset  <= 1'b1;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_req_ready  <= w_req_ready;
            r_rsp_valid  <= w_rsp_valid;
            r_rsp_lo     <= w_rsp_lo;
            r_rsp_hi     <= w_rsp_hi;
            r_rsp_is_div <= w_rsp_is_div;
            r_rsp_err    <= w_rsp_err;
            r_alu_a      <= w_alu_a;
            r_alu_b      <= w_alu_b;
            r_alu_signal <= w_alu_signal;
            r_alu_reset  <= w_alu_reset;
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_lo     = r_rsp_lo;
    assign bus.rsp_hi     = r_rsp_hi;
    assign bus.rsp_is_div = r_rsp_is_div;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.alu_dataA  = r_alu_a;
    assign bus.alu_dataB  = r_alu_b;
    assign bus.alu_signal = r_alu_signal;
    assign bus.alu_reset  = r_alu_reset;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed requests, scoreboard queue, decoupled response monitor.
// Includes a behavioural TotalALU stand-in (combinational ops, registered hi/lo for DIVU).
// Response backpressure is driven directly by the stimulus process.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_issue_ctrl_if bus();

    alu_issue_ctrl #(.OP_WAIT(1), .DIV_WAIT(35)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        is_div;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    // ALU stand-in
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    always @(posedge clk) begin
        if (bus.alu_reset) begin
            m_hi <= '0;
            m_lo <= '0;
        end else if (bus.alu_signal == 6'd27 && bus.alu_dataB != 0) begin
            m_hi <= bus.alu_dataA % bus.alu_dataB;
            m_lo <= bus.alu_dataA / bus.alu_dataB;
        end
    end
    always_comb begin
        bus.alu_out = '0;
        case (bus.alu_signal)
            6'd36: bus.alu_out = bus.alu_dataA & bus.alu_dataB;
            6'd37: bus.alu_out = bus.alu_dataA | bus.alu_dataB;
            6'd32: bus.alu_out = bus.alu_dataA + bus.alu_dataB;
            6'd34: bus.alu_out = bus.alu_dataA - bus.alu_dataB;
            6'd42: bus.alu_out = ($signed(bus.alu_dataA) < $signed(bus.alu_dataB)) ? 32'd1 : 32'd0;
            6'd2:  bus.alu_out = bus.alu_dataA >> bus.alu_dataB[4:0];
            6'd16: bus.alu_out = m_hi;
            6'd18: bus.alu_out = m_lo;
            default: bus.alu_out = '0;
        endcase
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latency on rsp_valid rise, field compare on each handshake
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            if (bus.rsp_valid && !prev_valid && exp_q.size() != 0)
                chk("latency", 32'(cyc - acc_cyc), 32'(exp_q[0].lat));
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    chk("rsp_lo", bus.rsp_lo, exp_q[0].lo);
                    chk("rsp_hi", bus.rsp_hi, exp_q[0].hi);
                    chk("rsp_is_div", 32'(bus.rsp_is_div), 32'(exp_q[0].is_div));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
                    void'(exp_q.pop_front());
                end
            end
        end
        prev_valid = reset && bus.rsp_valid;
    end

    // ALU drive activity counters for the DIVU / illegal windows
    logic mon_en = 1'b0;
    int n_rst = 0, n_27 = 0, n_16 = 0, n_18 = 0, n_not36 = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.alu_reset) n_rst++;
            if (bus.alu_signal == 6'd27 && !bus.alu_reset) n_27++;
            if (bus.alu_signal == 6'd16) n_16++;
            if (bus.alu_signal == 6'd18) n_18++;
            if (bus.alu_signal != 6'd36) n_not36++;
        end
    end

    task automatic clear_counts();
        n_rst = 0; n_27 = 0; n_16 = 0; n_18 = 0; n_not36 = 0;
    endtask

    task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] elo, input logic [31:0] ehi,
                        input logic ediv, input logic eerr, input int lat, input bit expect_rsp);
        exp_t e;
        int guard;
        e.lo = elo; e.hi = ehi; e.is_div = ediv; e.err = eerr; e.lat = lat;
        guard = 0;
        bus.req_funct = f;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.req_ready) begin
            chk("req_timeout", 32'd1, 32'd0);
            bus.req_valid = 1'b0;
        end else begin
            if (expect_rsp) exp_q.push_back(e);
            @(posedge clk); #1;
            acc_cyc = cyc;
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    int a1, a2, n_valid;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_funct = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;

        // Reset held for three edges
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_alu_reset", 32'(bus.alu_reset), 32'd1);
        chk("rst_alu_signal", 32'(bus.alu_signal), 32'd36);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("post_rst_alu_reset", 32'(bus.alu_reset), 32'd0);

        // ADD 7+5
        bus.rsp_ready = 1'b1;
        send(6'd32, 32'd7, 32'd5, 32'd12, 32'd0, 1'b0, 1'b0, 1, 1'b1);
        drain();

        // SLT then SUB back to back
        send(6'd42, 32'd3, 32'd9, 32'd1, 32'd0, 1'b0, 1'b0, 1, 1'b1);
        a1 = acc_cyc;
        send(6'd34, 32'd3, 32'd9, 32'hFFFF_FFFA, 32'd0, 1'b0, 1'b0, 1, 1'b1);
        a2 = acc_cyc;
        chk("b2b_spacing", 32'(a2 - a1), 32'd3);
        drain();

        // DIVU 100/7
        clear_counts();
        mon_en = 1'b1;
        send(6'd27, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1, 1'b0, 38, 1'b1);
        drain();
        mon_en = 1'b0;
        chk("div_rst_pulse", 32'(n_rst), 32'd1);
        chk("div_sig27_cycles", 32'(n_27), 32'd35);
        chk("div_sig16_cycles", 32'(n_16), 32'd1);
        chk("div_sig18_cycles", 32'(n_18), 32'd1);

        // Illegal funct
        clear_counts();
        mon_en = 1'b1;
        send(6'd5, 32'd11, 32'd22, 32'd0, 32'd0, 1'b0, 1'b1, 1, 1'b1);
        drain();
        mon_en = 1'b0;
        chk("illegal_alu_quiet", 32'(n_not36), 32'd0);

        // OR with response backpressure for 10 cycles
        bus.rsp_ready = 1'b0;
        send(6'd37, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 32'd0, 1'b0, 1'b0, 1, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_lo", bus.rsp_lo, 32'h0000_00FF);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        drain();

        // Reset mid-DRUN discards the division
        send(6'd27, 32'd50, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("midrst_alu_reset", 32'(bus.alu_reset), 32'd1);
        chk("midrst_alu_signal", 32'(bus.alu_signal), 32'd36);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        reset = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) n_valid++;
        end
        chk("midrst_no_rsp", 32'(n_valid), 32'd0);
        chk("midrst_idle_ready", 32'(bus.req_ready), 32'd1);

        // Normal operation after the abort
        send(6'd36, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 32'd0, 1'b0, 1'b0, 1, 1'b1);
        drain();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
